// File: rtl/writeback_stage.sv
// Final pipeline stage: registers the MEM-stage result, extracts load data and
// drives the register file write port, the forwarding bus and the retire counter.
module writeback_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic            reg_write_in,
  input  logic [4:0]      rd_in,
  input  logic [1:0]      wb_sel,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] pc_plus4,
  output logic            RegWrite,
  output logic [4:0]      WriteRegister,
  output logic [XLEN-1:0] WriteData,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            load_fault,
  output logic [XLEN-1:0] instret
);

  logic            capture;
  logic [2:0]      off;
  logic [7:0]      byteVal;
  logic [15:0]     halfVal;
  logic [31:0]     wordVal;
  logic [XLEN-1:0] loadVal;
  logic            loadErr;
  logic [XLEN-1:0] writeData_d;
  logic            loadFault_d;
  logic            regWrite_d;

  logic            regWrite_q;
  logic [4:0]      writeReg_q;
  logic [XLEN-1:0] writeData_q;
  logic            loadFault_q;
  logic [XLEN-1:0] instret_q;

  // Flush wins over stall; both simply turn the capture into a bubble.
  assign capture = in_valid & ~stall & ~flush;
  assign off     = alu_result[2:0];
  assign byteVal = mem_rdata[{off, 3'b000} +: 8];
  assign halfVal = mem_rdata[{off[2:1], 4'b0000} +: 16];
  assign wordVal = mem_rdata[{off[2], 5'b00000} +: 32];

  always_comb begin
    loadVal = '0;
    loadErr = 1'b0;
    unique case (funct3)
      3'b000: loadVal = {{(XLEN-8){byteVal[7]}}, byteVal};
      3'b100: loadVal = {{(XLEN-8){1'b0}}, byteVal};
      3'b001: begin
        loadVal = {{(XLEN-16){halfVal[15]}}, halfVal};
        loadErr = off[0];
      end
      3'b101: begin
        loadVal = {{(XLEN-16){1'b0}}, halfVal};
        loadErr = off[0];
      end
      3'b010: begin
        loadVal = {{(XLEN-32){wordVal[31]}}, wordVal};
        loadErr = (off[1:0] != 2'b00);
      end
      3'b110: begin
        loadVal = {{(XLEN-32){1'b0}}, wordVal};
        loadErr = (off[1:0] != 2'b00);
      end
      3'b011: begin
        loadVal = mem_rdata;
        loadErr = (off != 3'b000);
      end
      default: loadErr = 1'b1;
    endcase
  end

  // An illegal select zeroes the data and can never write or fault.
  always_comb begin
    writeData_d = '0;
    unique case (wb_sel)
      2'b00:   writeData_d = alu_result;
      2'b01:   writeData_d = loadVal;
      2'b10:   writeData_d = pc_plus4;
      default: writeData_d = '0;
    endcase
    loadFault_d = (wb_sel == 2'b01) & loadErr;
    regWrite_d  = reg_write_in & (rd_in != 5'd0) & ~loadFault_d & (wb_sel != 2'b11);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWrite_q  <= 1'b0;
      writeReg_q  <= 5'd0;
      writeData_q <= '0;
      loadFault_q <= 1'b0;
      instret_q   <= '0;
    end else if (capture) begin
      regWrite_q  <= regWrite_d;
      writeReg_q  <= rd_in;
      writeData_q <= writeData_d;
      loadFault_q <= loadFault_d;
      instret_q   <= instret_q + 1'b1;
    end else begin
      regWrite_q  <= 1'b0;
      loadFault_q <= 1'b0;
    end
  end

  assign RegWrite      = regWrite_q;
  assign WriteRegister = writeReg_q;
  assign WriteData     = writeData_q;
  assign fwd_valid     = regWrite_q;
  assign fwd_rd        = writeReg_q;
  assign fwd_data      = writeData_q;
  assign load_fault    = loadFault_q;
  assign instret       = instret_q;

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the 64-bit RISC-V core, directly upstream of the register file write port. It registers MEM-stage results, extracts and sign- or zero-extends load data, and selects the ALU result, the load value or PC+4. It drives the register file's `RegWrite`, `WriteRegister` and `WriteData` inputs, suppresses writes to x0 and to faulting loads, exposes a forwarding copy of the result, and counts retired instructions.

## Interface
- `XLEN`, 64: datapath width. Only 64 is supported.
- `clk`  in  1  single clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  MEM stage presents a valid instruction.
- `stall`  in  1  MEM stage stalled. The stage captures a bubble.
- `flush`  in  1  squash. The stage captures a bubble. Has priority over everything else.
- `reg_write_in`  in  1  the instruction writes rd.
- `rd_in`  in  5  destination register.
- `wb_sel`  in  2  result select: 00 = ALU, 01 = load, 10 = PC+4, 11 = illegal.
- `funct3`  in  3  load size and sign for `wb_sel` = 01.
- `alu_result`  in  64  ALU result; for loads, the effective address.
- `mem_rdata`  in  64  aligned 64-bit doubleword from data memory.
- `pc_plus4`  in  64  link value.
- `RegWrite`  out  1  register file write enable.
- `WriteRegister`  out  5  register file write address.
- `WriteData`  out  64  register file write data.
- `fwd_valid`  out  1  the forwarding bus carries a pending write (equals `RegWrite`).
- `fwd_rd`  out  5  forwarding register number.
- `fwd_data`  out  64  forwarding data (equals `WriteData`).
- `load_fault`  out  1  the captured load was misaligned or had an illegal encoding.
- `instret`  out  64  retired-instruction counter.

## Operation
- **Capture condition:** at each posedge, capture = `in_valid & ~stall & ~flush`. Otherwise the stage loads a bubble: valid = 0, `RegWrite` = 0, `load_fault` = 0. The data outputs hold their previous values.
- **Load extraction:** the byte offset is `alu_result[2:0]`.
  - 000 LB and 100 LBU: byte lane `off`.
  - 001 LH and 101 LHU: halfword at `off[2:1]`.
  - 010 LW and 110 LWU: word at `off[2]`.
  - 011 LD: full doubleword.
  - Signed forms sign-extend to 64 bits; U forms zero-extend.
- **Misalignment:**
  - A halfword with `off[0]` = 1 is misaligned.
  - A word with `off[1:0]` ≠ 0 is misaligned.
  - A doubleword with `off` ≠ 0 is misaligned.
  - `funct3` = 111 is an illegal encoding.
  - Any of these, when `wb_sel` = 01, sets `load_fault` = 1 and forces `RegWrite` = 0 for that instruction.
- **Result select:** `wb_sel` = 11 on a captured instruction forces `RegWrite` = 0, `load_fault` = 0, and `WriteData` = 0.
- **Write enable:** `RegWrite` = captured & `reg_write_in` & (`rd_in` ≠ 0) & no fault & `wb_sel` ≠ 11.
- **Retire counter:** `instret` increments by 1 for every captured instruction, including faulting ones and ones that do not write. It wraps from 2^64−1 to 0.
- **Extraction path:** all extraction and select logic is combinational on the inputs. Only the final values are registered.

## Timing
- **Reset values:** all outputs are 0 while `reset` is high, and the reset acts immediately (asynchronous). `instret` = 0.
- **Reset mid-operation:** an in-flight write is dropped. It is never presented to the register file after reset deasserts.
- **Latency:** 1 cycle. An instruction captured at edge N drives `RegWrite`/`WriteRegister`/`WriteData` during cycle N→N+1. The register file commits it at edge N+1.
- **Per-instruction strobe:** each instruction produces exactly one `RegWrite` pulse, one cycle wide. Back-to-back captures produce back-to-back pulses.
- **`instret` update:** updates at the same edge as the capture. It is visible in cycle N→N+1.
- **`stall` and `flush` together:** treated as a flush. The result is a bubble.
- **Forwarding:** the `fwd_*` outputs are identical to the write-port outputs in the same cycle. The decode stage must combine them with the register file read, which does not bypass same-cycle writes.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle after capturing an ALU write to x5. Required: `RegWrite`, `WriteData` and `instret` go to 0 immediately, and no write to x5 occurs after release.
- **ALU and link writes:** capture ALU write x3 = 0x1234 at edge N. Required: `RegWrite` = 1, `WriteRegister` = 3 and `WriteData` = 0x1234 in cycle N only. Then capture `wb_sel` = 10 to x1 with `pc_plus4` = 0x104. Required: `WriteData` = 0x104.
- **Load extraction:** `mem_rdata` = 0x8877_6655_4433_2281.
  - LB at `off` 0 → 0xFFFF_FFFF_FFFF_FF81.
  - LBU at `off` 0 → 0x81.
  - LH at `off` 6 → 0xFFFF_FFFF_FFFF_8877.
  - LWU at `off` 4 → 0x8877_6655.
  - LD at `off` 0 → full value.
- **Faults and x0:**
  - LW at `off` 2 → `load_fault` = 1, `RegWrite` = 0, and `instret` increments.
  - Valid ALU write to x0 → `RegWrite` = 0.
- **Stall and flush:** `in_valid` = 1 with `stall` = 1, then with `flush` = 1, then with both high. Required: no `RegWrite` pulse and no `instret` change in any of the three cases.
- **Counter wrap:** preload `instret` to 2^64−1 by forcing it, then capture one instruction. Required: `instret` = 0.
